// File: rtl/cpu_mem_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cpu_mem_bus_arbiter_pkg
// Shared types and defaults for the memory-bus arbiter and its round-robin
// picker.
//   arb_state_t : arbiter FSM encoding (IDLE -> ISSUE -> WAIT -> RESP)
//   DEF_*       : default widths / timeout used when the top is not overridden
//   TIMER_W     : width of the WAIT-state timeout counter
//   idx_width() : index width for N requesters (at least 1 bit)
// ----------------------------------------------------------------------------
package cpu_mem_bus_arbiter_pkg;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 64;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int TIMER_W            = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_rr_picker.sv
// ----------------------------------------------------------------------------
// cpu_rr_picker
// Combinational round-robin selector: picks the first asserted request bit
// searching upward from i_last+1, wrapping at N.
//   i_req   in  N      request vector
//   i_last  in  IDX_W  index of the previous winner
//   o_grant out N      one-hot winner (all zero when no request)
//   o_idx   out IDX_W  index of the winner (0 when no request)
// ----------------------------------------------------------------------------
module cpu_rr_picker
    import cpu_mem_bus_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    function automatic int rr_pos(input logic [IDX_W-1:0] last, input int off);
        return (int'(last) + off) % N;
    endfunction

    // Walk the offsets from farthest to nearest so the nearest requester
    // after i_last is the last one written and therefore wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        for (int off = N; off >= 1; off--) begin
            if (i_req[rr_pos(i_last, off)]) begin
                o_grant                      = '0;
                o_grant[rr_pos(i_last, off)] = 1'b1;
                o_idx                        = IDX_W'(rr_pos(i_last, off));
            end
        end
    end

endmodule

// File: rtl/cpu_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_mem_bus_arbiter
// Shares one memory bus among NUM_REQ cache/TLB requesters. Round-robin
// grant, one outstanding transaction, timeout error response if memory
// never answers.
//   i_clock / i_reset         clock, synchronous active-high reset
//   i_req_valid/_write        per-requester request strobe and direction
//   i_req_addr / i_req_data   packed per-requester address / write data
//   o_mem_bus_available       arbiter idle (all bits equal)
//   o_req_grant               one-hot accept, combinational in IDLE
//   o_resp_valid              one-hot one-cycle response pulse to owner
//   o_resp_data / _error      read data (0 for writes/errors), timeout flag
//   o_mem_req_*               request to memory, held until i_mem_req_ready
//   i_mem_resp_valid / _data  memory response / write ack
//   o_spurious_resp           sticky: memory responded outside WAIT
// ----------------------------------------------------------------------------
module cpu_mem_bus_arbiter
    import cpu_mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_mem_bus_available,
    output logic [NUM_REQ-1:0]            o_req_grant,
    output logic [NUM_REQ-1:0]            o_resp_valid,
    output logic [DATA_WIDTH-1:0]         o_resp_data,
    output logic                          o_resp_error,
    output logic                          o_mem_req_valid,
    output logic                          o_mem_req_write,
    output logic [ADDR_WIDTH-1:0]         o_mem_req_addr,
    output logic [DATA_WIDTH-1:0]         o_mem_req_data,
    input  logic                          i_mem_req_ready,
    input  logic                          i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]         i_mem_resp_data,
    output logic                          o_spurious_resp
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [IDX_W-1:0]       r_rr_last;
    logic [IDX_W-1:0]       r_owner;
    logic                   r_write;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [TIMER_W-1:0]     r_timer;
    logic [DATA_WIDTH-1:0]  r_resp_data;
    logic                   r_resp_error;
    logic                   r_spurious;

    logic [NUM_REQ-1:0]     w_pick_grant;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_any_req;
    logic                   w_timeout;
    logic [ADDR_WIDTH-1:0]  w_addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]  w_data_arr [NUM_REQ];

    cpu_rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (i_req_valid),
        .i_last  (r_rr_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_addr_arr[gi]   = i_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_data_arr[gi]   = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign o_resp_valid[gi] = (r_state == ARB_RESP) && (r_owner == IDX_W'(gi));
        end
    endgenerate

    assign w_any_req = |i_req_valid;
    assign w_timeout = (r_timer == TIMER_W'(TIMEOUT_CYCLES));

    // Next state and FSM-decoded outputs.
    always_comb begin
        w_state_next        = r_state;
        o_mem_bus_available = '0;
        o_req_grant         = '0;
        o_mem_req_valid     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                o_mem_bus_available = '1;
                o_req_grant         = w_pick_grant;
                if (w_any_req) begin
                    w_state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    w_state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (i_mem_resp_valid || w_timeout) begin
                    w_state_next = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ARB_IDLE;
            r_rr_last    <= IDX_W'(NUM_REQ - 1);
            r_owner      <= '0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_timer      <= '0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Any memory response outside WAIT (including one that arrives
            // after a timeout) is dropped and flagged until reset.
            if (i_mem_resp_valid && (r_state != ARB_WAIT)) begin
                r_spurious <= 1'b1;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_pick_idx;
                        r_rr_last <= w_pick_idx;
                        r_write   <= i_req_write[w_pick_idx];
                        r_addr    <= w_addr_arr[w_pick_idx];
                        r_data    <= w_data_arr[w_pick_idx];
                    end
                end
                ARB_ISSUE: begin
                    if (i_mem_req_ready) begin
                        r_timer <= '0;
                    end
                end
                ARB_WAIT: begin
                    if (r_timer != '1) begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                    // A response landing on the timeout cycle takes priority.
                    if (i_mem_resp_valid) begin
                        r_resp_data  <= r_write ? '0 : i_mem_resp_data;
                        r_resp_error <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_data  <= '0;
                        r_resp_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_resp_data     = (r_state == ARB_RESP) ? r_resp_data  : '0;
    assign o_resp_error    = (r_state == ARB_RESP) ? r_resp_error : 1'b0;
    assign o_mem_req_write = r_write;
    assign o_mem_req_addr  = r_addr;
    assign o_mem_req_data  = r_data;
    assign o_spurious_resp = r_spurious;

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cpu_mem_bus_arbiter
// Directed stimulus for the memory-bus arbiter. Each issued transaction
// pushes its expected response (owner, data, error, arrival cycle) into a
// queue; an independent monitor pops and compares whenever resp_valid fires.
// ----------------------------------------------------------------------------
module tb_cpu_mem_bus_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_write = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic             mem_req_ready  = 1'b0;
    logic             mem_resp_valid = 1'b0;
    logic [DW-1:0]    mem_resp_data  = '0;

    logic [NR-1:0]    o_avail;
    logic [NR-1:0]    o_grant;
    logic [NR-1:0]    o_resp_valid;
    logic [DW-1:0]    o_resp_data;
    logic             o_resp_error;
    logic             o_mem_req_valid;
    logic             o_mem_req_write;
    logic [AW-1:0]    o_mem_req_addr;
    logic [DW-1:0]    o_mem_req_data;
    logic             o_spurious;

    always #5 clk = ~clk;

    cpu_mem_bus_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_req_valid         (req_valid),
        .i_req_write         (req_write),
        .i_req_addr          (req_addr),
        .i_req_data          (req_data),
        .o_mem_bus_available (o_avail),
        .o_req_grant         (o_grant),
        .o_resp_valid        (o_resp_valid),
        .o_resp_data         (o_resp_data),
        .o_resp_error        (o_resp_error),
        .o_mem_req_valid     (o_mem_req_valid),
        .o_mem_req_write     (o_mem_req_write),
        .o_mem_req_addr      (o_mem_req_addr),
        .o_mem_req_data      (o_mem_req_data),
        .i_mem_req_ready     (mem_req_ready),
        .i_mem_resp_valid    (mem_resp_valid),
        .i_mem_resp_data     (mem_resp_data),
        .o_spurious_resp     (o_spurious)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
        logic          err;
        int            at;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (o_resp_valid != '0)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid=%b expected none (cycle %0d)",
                             o_resp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_valid", DW'(o_resp_valid), DW'(e.vld));
                    chk("resp_data",  o_resp_data, e.data);
                    chk("resp_error", DW'(o_resp_error), DW'(e.err));
                    chk("resp_cycle", DW'(cyc), DW'(e.at));
                    $display("resp: owner=%b data=%h err=%b cycle=%0d (expected cycle %0d)",
                             o_resp_valid, o_resp_data, o_resp_error, cyc, e.at);
                end
            end
        end
    end

    // Runs one transaction starting just after a rising edge with the DUT in
    // IDLE; returns just after the edge that brings it back to IDLE.
    // rsp_dly < 0 means memory never answers (timeout path).
    task automatic run_txn(input string nm, input logic [NR-1:0] reqs,
                           input logic [NR-1:0] exp_g, input int rdy_dly,
                           input int rsp_dly, input logic [DW-1:0] mdata);
        int            w;
        logic          wr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        exp_t          e;
        req_valid = reqs;
        @(negedge clk);
        chk({nm, "_grant"}, DW'(o_grant), DW'(exp_g));
        chk({nm, "_avail_idle"}, DW'(o_avail), DW'(2'b11));
        w  = exp_g[1] ? 1 : 0;
        wr = req_write[w];
        ea = req_addr[w*AW +: AW];
        ed = req_data[w*DW +: DW];
        e.vld  = exp_g;
        e.err  = (rsp_dly < 0);
        e.data = (rsp_dly < 0 || wr) ? '0 : mdata;
        e.at   = (rsp_dly < 0) ? (cyc + 2 + rdy_dly + TO + 1) : (cyc + 3 + rdy_dly + rsp_dly);
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 0; k <= rdy_dly; k++) begin
            mem_req_ready = (k == rdy_dly);
            @(negedge clk);
            chk({nm, "_mreq_valid"}, DW'(o_mem_req_valid), DW'(1'b1));
            chk({nm, "_mreq_addr"},  DW'(o_mem_req_addr), DW'(ea));
            chk({nm, "_mreq_data"},  o_mem_req_data, ed);
            chk({nm, "_mreq_write"}, DW'(o_mem_req_write), DW'(wr));
            chk({nm, "_avail_busy"}, DW'(o_avail), DW'(2'b00));
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
        if (rsp_dly >= 0) begin
            for (int k = 0; k <= rsp_dly; k++) begin
                mem_resp_valid = (k == rsp_dly);
                mem_resp_data  = mdata;
                @(negedge clk);
                if (k == 0) begin
                    chk({nm, "_wait_mreq"}, DW'(o_mem_req_valid), DW'(1'b0));
                end
                @(posedge clk); #1;
            end
            mem_resp_valid = 1'b0;
        end else begin
            mem_resp_data = mdata;
            repeat (TO + 1) @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk({nm, "_avail_resp"}, DW'(o_avail), DW'(2'b00));
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_avail",      DW'(o_avail), DW'(2'b11));
        chk("rst_grant",      DW'(o_grant), DW'(2'b00));
        chk("rst_resp_valid", DW'(o_resp_valid), DW'(2'b00));
        chk("rst_resp_data",  o_resp_data, '0);
        chk("rst_mreq_valid", DW'(o_mem_req_valid), DW'(1'b0));
        chk("rst_spurious",   DW'(o_spurious), DW'(1'b0));
        @(posedge clk); #1;

        // Round-robin alternation with both requesting
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_data = {64'hAAAA_0001, 64'hBBBB_0000};
        run_txn("t1a", 2'b11, 2'b01, 0, 0, 64'h1111);
        run_txn("t1b", 2'b11, 2'b10, 0, 0, 64'h2222);
        run_txn("t1c", 2'b11, 2'b01, 0, 0, 64'h3333);

        // Read by requester 1 with immediate ready/response
        req_addr = {32'h0000_0040, 32'h0000_0100};
        run_txn("t2", 2'b10, 2'b10, 0, 0, 64'hDEAD);

        // Write by requester 0 with 5 cycles of backpressure; ack data ignored
        req_write = 2'b01;
        req_addr  = {32'h0000_0040, 32'h0000_0080};
        req_data  = {64'h0, 64'hCAFE_F00D_1234_5678};
        run_txn("t3", 2'b01, 2'b01, 5, 0, 64'h5555);
        req_write = 2'b00;

        // Response exactly on the timeout cycle wins
        run_txn("t6", 2'b10, 2'b10, 0, TO, 64'hBEEF);

        // Timeout, then a late ack marks spurious
        run_txn("t4", 2'b01, 2'b01, 0, -1, 64'h77);
        @(negedge clk);
        chk("t4_spurious_before", DW'(o_spurious), DW'(1'b0));
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("t4_spurious_after", DW'(o_spurious), DW'(1'b1));
        @(posedge clk); #1;

        // Reset while waiting on memory: abandon, no response, rr pointer reset
        req_valid = 2'b01;
        @(negedge clk);
        chk("t5_grant", DW'(o_grant), DW'(2'b01));
        @(posedge clk); #1;
        req_valid     = 2'b00;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_avail",      DW'(o_avail), DW'(2'b11));
        chk("t5_resp_valid", DW'(o_resp_valid), DW'(2'b00));
        chk("t5_mreq_valid", DW'(o_mem_req_valid), DW'(1'b0));
        chk("t5_spurious",   DW'(o_spurious), DW'(1'b0));
        @(posedge clk); #1;
        run_txn("t5_rr", 2'b11, 2'b01, 0, 0, 64'h9999);

        repeat (2) @(negedge clk);
        chk("sb_empty", DW'(sb.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
